cmd_frame_parser: RTL and testbench

Parametrised command-frame parser between the UART receiver and the register file.
- Hunts for a start-of-frame byte, then collects a CMD byte, ADDR_BYTES address bytes and DATA_BYTES data bytes.
- Presents the assembled command on a valid/ready interface.
- Adds byte-timeout resynchronisation, backpressure and error reporting.
- Transport is byte-serial: one rx_valid pulse per byte.

---
 rtl/cmd_frame_parser_pkg.sv | 21 ++
 rtl/cmd_frame_parser_timer.sv | 28 ++
 rtl/cmd_frame_parser.sv | 175 +++++++++++++++++
 tb/tb_cmd_frame_parser.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_frame_parser_pkg.sv
// Shared types and constants for the command-frame parser.
// The optional checksum byte is enabled by defining CMD_FRAME_CHECKSUM_EN.
package cmd_pkg;

  typedef enum logic [2:0] {
    S_SOF  = 3'd0,
    S_CMD  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_HOLD = 3'd5
  } state_e;

  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  localparam logic [7:0] DEFAULT_SOF_BYTE = 8'hA5;
  localparam int         MAX_FIELD_BYTES  = 4;

endpackage

// File: rtl/cmd_frame_parser_timer.sv
// Inter-byte idle counter: cleared on every accepted byte, saturates at the
// last allowed idle cycle and flags it as expired.
module frame_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != LAST)) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign expired_o = (count_q == LAST);

endmodule

// File: rtl/cmd_frame_parser.sv
// Byte-serial command-frame parser: SOF, CMD, ADDR, DATA[, CSUM] -> valid/ready.
// Define CMD_FRAME_CHECKSUM_EN to require a trailing XOR checksum byte.
module cmd_frame_parser
  import cmd_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE       = DEFAULT_SOF_BYTE,
  parameter int         ADDR_BYTES     = 1,
  parameter int         DATA_BYTES     = 1,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [7:0]              cmd,
  output logic [8*ADDR_BYTES-1:0] addr,
  output logic [8*DATA_BYTES-1:0] data,
  output logic                    err_valid,
  output logic [1:0]              err_code,
  output logic                    busy,
  output state_e                  state_dbg
);

  localparam int         AW        = 8 * ADDR_BYTES;
  localparam int         DW        = 8 * DATA_BYTES;
  localparam logic [1:0] ADDR_LAST = 2'(ADDR_BYTES - 1);
  localparam logic [1:0] DATA_LAST = 2'(DATA_BYTES - 1);

  // Handshake: a command transfers on any clock edge where cmd_valid and
  // cmd_ready are both high; cmd/addr/data are stable while cmd_valid is high.
  state_e          state_q;
  logic [1:0]      cnt_q;
  logic [7:0]      cmd_sh_q, cmd_q;
  logic [AW-1:0]   addr_sh_q, addr_q;
  logic [DW-1:0]   data_sh_q, data_q;
  logic            cmd_valid_q, err_valid_q;
  logic [1:0]      err_code_q;
  logic            in_frame, expired, timeout_hit;
  logic [AW-1:0]   addr_shift;
  logic [DW-1:0]   data_shift;

  assign in_frame    = state_q inside {S_CMD, S_ADDR, S_DATA, S_CSUM};
  assign timeout_hit = in_frame && expired && !rx_valid;
  assign addr_shift  = AW'({addr_sh_q, rx_data});
  assign data_shift  = DW'({data_sh_q, rx_data});

  frame_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (rx_valid || !in_frame),
    .en_i      (in_frame),
    .expired_o (expired)
  );

`ifdef CMD_FRAME_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk) begin
    if (rst || state_q == S_SOF) begin
      csum_q <= '0;
    end else if (rx_valid && (state_q inside {S_CMD, S_ADDR, S_DATA})) begin
      csum_q <= csum_q ^ rx_data;
    end
  end
`endif

  // Fields are assembled in shadow registers so a timed-out or corrupted
  // frame never disturbs the last presented command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_SOF;
      cnt_q       <= '0;
      cmd_sh_q    <= '0;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      cmd_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      err_valid_q <= 1'b0;
      if (timeout_hit) begin
        state_q     <= S_SOF;
        cnt_q       <= '0;
        err_valid_q <= 1'b1;
        err_code_q  <= ERR_TIMEOUT;
      end else begin
        case (state_q)
          S_SOF: begin
            cnt_q <= '0;
            if (rx_valid && rx_data == SOF_BYTE) state_q <= S_CMD;
          end
          S_CMD: begin
            if (rx_valid) begin
              cmd_sh_q <= rx_data;
              state_q  <= S_ADDR;
            end
          end
          S_ADDR: begin
            if (rx_valid) begin
              addr_sh_q <= addr_shift;
              if (cnt_q == ADDR_LAST) begin
                cnt_q   <= '0;
                state_q <= S_DATA;
              end else begin
                cnt_q <= cnt_q + 2'd1;
              end
            end
          end
          S_DATA: begin
            if (rx_valid) begin
              data_sh_q <= data_shift;
              if (cnt_q == DATA_LAST) begin
                cnt_q <= '0;
`ifdef CMD_FRAME_CHECKSUM_EN
                state_q <= S_CSUM;
`else
                state_q     <= S_HOLD;
                cmd_valid_q <= 1'b1;
                cmd_q       <= cmd_sh_q;
                addr_q      <= addr_sh_q;
                data_q      <= data_shift;
`endif
              end else begin
                cnt_q <= cnt_q + 2'd1;
              end
            end
          end
`ifdef CMD_FRAME_CHECKSUM_EN
          S_CSUM: begin
            if (rx_valid) begin
              if (rx_data == csum_q) begin
                state_q     <= S_HOLD;
                cmd_valid_q <= 1'b1;
                cmd_q       <= cmd_sh_q;
                addr_q      <= addr_sh_q;
                data_q      <= data_sh_q;
              end else begin
                state_q     <= S_SOF;
                err_valid_q <= 1'b1;
                err_code_q  <= ERR_CSUM;
              end
            end
          end
`endif
          S_HOLD: begin
            if (rx_valid) begin
              err_valid_q <= 1'b1;
              err_code_q  <= ERR_OVERRUN;
            end
            if (cmd_valid_q && cmd_ready) begin
              cmd_valid_q <= 1'b0;
              state_q     <= S_SOF;
            end
          end
          default: state_q <= S_SOF;
        endcase
      end
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;
  assign addr      = addr_q;
  assign data      = data_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q != S_SOF);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Scoreboard bench for cmd_frame_parser: a 1/1-byte instance and a 2/4-byte
// instance, both with a 16-cycle byte timeout.
module tb_cmd_frame_parser;
  import cmd_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- instance A: 1 addr byte, 1 data byte ----------------
  logic        rx_valid, cmd_ready;
  logic [7:0]  rx_data;
  logic        cmd_valid, err_valid, busy;
  logic [7:0]  cmd, addr, data;
  logic [1:0]  err_code;
  state_e      state_dbg;

  cmd_frame_parser #(.SOF_BYTE(8'hA5), .ADDR_BYTES(1), .DATA_BYTES(1), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .addr(addr), .data(data),
    .err_valid(err_valid), .err_code(err_code), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- instance W: 2 addr bytes, 4 data bytes ----------------
  logic        rx_valid_w, cmd_ready_w;
  logic [7:0]  rx_data_w;
  logic        cmd_valid_w, err_valid_w, busy_w;
  logic [7:0]  cmd_w;
  logic [15:0] addr_w;
  logic [31:0] data_w;
  logic [1:0]  err_code_w;
  state_e      state_dbg_w;

  cmd_frame_parser #(.SOF_BYTE(8'hA5), .ADDR_BYTES(2), .DATA_BYTES(4), .TIMEOUT_CYCLES(16)) dut_w (
    .clk(clk), .rst(rst), .rx_valid(rx_valid_w), .rx_data(rx_data_w),
    .cmd_valid(cmd_valid_w), .cmd_ready(cmd_ready_w), .cmd(cmd_w), .addr(addr_w), .data(data_w),
    .err_valid(err_valid_w), .err_code(err_code_w), .busy(busy_w), .state_dbg(state_dbg_w)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  // event = {is_err, err_code, cmd, addr, data}
  logic [26:0] exp_q[$];
  logic [58:0] exp_w_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_cmd_a(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({1'b0, 2'b00, c, a, d});
  endtask

  task automatic exp_err_a(input logic [1:0] code);
    exp_q.push_back({1'b1, code, 24'h0});
  endtask

  task automatic score_a(input logic [26:0] act);
    logic [26:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_a: got event %0h expected no event", act);
    end else begin
      e = exp_q.pop_front();
      check("scoreboard_a", 64'(act), 64'(e));
    end
  endtask

  task automatic score_w(input logic [58:0] act);
    logic [58:0] e;
    if (exp_w_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_w: got event %0h expected no event", act);
    end else begin
      e = exp_w_q.pop_front();
      check("scoreboard_w", 64'(act), 64'(e));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (err_valid) score_a({1'b1, err_code, 24'h0});
      if (cmd_valid && cmd_ready) score_a({1'b0, 2'b00, cmd, addr, data});
      if (err_valid_w) score_w({1'b1, err_code_w, 56'h0});
      if (cmd_valid_w && cmd_ready_w) score_w({1'b0, 2'b00, cmd_w, addr_w, data_w});
    end
  end

  // ---------------- drivers ----------------
  task automatic send_a(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_w(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid_w = 1'b1;
    rx_data_w  = b;
    @(posedge clk); #1;
    rx_valid_w = 1'b0;
  endtask

  task automatic frame_a(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
    send_a(8'hA5);
    send_a(c);
    send_a(a);
    send_a(d);
`ifdef CMD_FRAME_CHECKSUM_EN
    send_a(c ^ a ^ d);
`endif
  endtask

  task automatic cycle;
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] w_bytes [8];
  logic       flag;

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0; rx_data = '0; cmd_ready = 1'b1;
    rx_valid_w = 1'b0; rx_data_w = '0; cmd_ready_w = 1'b1;
    repeat (3) cycle();

    check("reset_cmd_valid", cmd_valid, 0);
    check("reset_err_valid", err_valid, 0);
    check("reset_err_code", err_code, 0);
    check("reset_busy", busy, 0);
    check("reset_fields", {cmd, addr, data}, 0);
    check("reset_state", 64'(state_dbg), 64'(S_SOF));
    check("reset_w_fields", {cmd_w, addr_w, data_w, busy_w}, 0);
    rst = 1'b0;
    cycle();

    // Basic frame with ready high: one-cycle valid right after the last byte
    exp_cmd_a(8'h01, 8'h10, 8'h55);
    frame_a(8'h01, 8'h10, 8'h55);
    check("t1_valid_rise", cmd_valid, 1);
    check("t1_fields", {cmd, addr, data}, 24'h011055);
    cycle();
    check("t1_valid_one_cycle", cmd_valid, 0);
    check("t1_busy_after", busy, 0);

    // Wide instance, big-endian assembly
    w_bytes = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    exp_w_q.push_back({1'b0, 2'b00, 8'h02, 16'h1234, 32'hDEADBEEF});
    foreach (w_bytes[i]) send_w(w_bytes[i]);
`ifdef CMD_FRAME_CHECKSUM_EN
    send_w(8'h06);
`endif
    check("t2_w_valid", cmd_valid_w, 1);
    check("t2_w_fields", {cmd_w, addr_w, data_w}, {8'h02, 16'h1234, 32'hDEADBEEF});
    cycle();

    // Garbage before SOF is discarded
    send_a(8'h00);
    send_a(8'hFF);
    check("t3_idle_after_garbage", busy, 0);
    exp_cmd_a(8'h03, 8'h20, 8'h7E);
    frame_a(8'h03, 8'h20, 8'h7E);
    cycle();

    // Timeout: 16 cycles after byte 01 with silence
    exp_err_a(ERR_TIMEOUT);
    send_a(8'hA5);
    send_a(8'h01);
    check("t4_busy_in_frame", busy, 1);
    flag = 1'b0;
    for (int i = 1; i < 16; i++) begin
      cycle();
      flag = flag | err_valid;
    end
    check("t4_no_early_err", flag, 0);
    cycle();
    check("t4_err_valid", err_valid, 1);
    check("t4_err_code", err_code, ERR_TIMEOUT);
    check("t4_busy_cleared", busy, 0);
    check("t4_no_cmd_valid", cmd_valid, 0);
    check("t4_fields_kept", {cmd, addr, data}, 24'h03207E);
    exp_cmd_a(8'h0A, 8'h0B, 8'h0C);
    frame_a(8'h0A, 8'h0B, 8'h0C);
    cycle();

    // A byte landing in the expiry cycle wins over the timeout
    exp_cmd_a(8'h01, 8'h40, 8'h5A);
    send_a(8'hA5);
    send_a(8'h01);
    repeat (14) @(posedge clk);
    send_a(8'h40);
    check("t4b_byte_wins", busy, 1);
    send_a(8'h5A);
`ifdef CMD_FRAME_CHECKSUM_EN
    send_a(8'h1B);
`endif
    check("t4b_valid", cmd_valid, 1);
    cycle();

    // Backpressure and overrun
    cmd_ready = 1'b0;
    frame_a(8'h04, 8'h30, 8'h66);
    flag = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      flag = flag & cmd_valid;
    end
    check("t5_valid_held", flag, 1);
    exp_err_a(ERR_OVERRUN);
    send_a(8'h99);
    check("t5_overrun_valid", err_valid, 1);
    check("t5_overrun_code", err_code, ERR_OVERRUN);
    check("t5_fields_held", {cmd_valid, cmd, addr, data}, {1'b1, 24'h043066});
    exp_err_a(ERR_OVERRUN);
    send_a(8'hA5);
    check("t5_sof_overrun", {err_valid, err_code, cmd}, {1'b1, ERR_OVERRUN, 8'h04});
    exp_cmd_a(8'h04, 8'h30, 8'h66);
    cmd_ready = 1'b1;
    cycle();
    check("t5_handshake_done", {cmd_valid, busy}, 2'b00);

    // Reset mid-frame and mid-HOLD
    send_a(8'hA5);
    send_a(8'h07);
    rst = 1'b1;
    cycle();
    check("t6_reset_mid_frame", {busy, cmd_valid, cmd, addr, data}, 0);
    rst = 1'b0;
    cmd_ready = 1'b0;
    frame_a(8'h08, 8'h09, 8'h0A);
    check("t6_hold_before_reset", cmd_valid, 1);
    rst = 1'b1;
    cycle();
    check("t6_reset_mid_hold", {busy, cmd_valid, cmd, addr, data}, 0);
    rst = 1'b0;
    cmd_ready = 1'b1;
    exp_cmd_a(8'h0B, 8'h0C, 8'h0D);
    frame_a(8'h0B, 8'h0C, 8'h0D);
    cycle();

`ifdef CMD_FRAME_CHECKSUM_EN
    exp_cmd_a(8'h01, 8'h10, 8'h55);
    send_a(8'hA5); send_a(8'h01); send_a(8'h10); send_a(8'h55); send_a(8'h44);
    check("t7_csum_ok", cmd_valid, 1);
    cycle();
    exp_err_a(ERR_CSUM);
    send_a(8'hA5); send_a(8'h01); send_a(8'h10); send_a(8'h55); send_a(8'h45);
    check("t7_csum_bad", {err_valid, err_code, cmd_valid, busy}, {1'b1, ERR_CSUM, 2'b00});
    cycle();
`endif

    repeat (5) cycle();
    check("queue_a_drained", exp_q.size(), 0);
    check("queue_w_drained", exp_w_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1);
  end

endmodule
